// File: rtl/kuznechik_pkg.sv
// rtl/kuznechik_pkg.sv - shared constants, FSM encoding and GF(2^8) helper for the Kuznyechik encrypt core
package kuznechik_pkg;

  localparam int unsigned KUZ_ROUNDS = 9;
  localparam int unsigned R_STEPS    = 16;
  localparam logic [8:0]  GF_POLY    = 9'h1C3;

  // Indexed by byte position: entry i multiplies byte a_i (a0 sits in bits [7:0]).
  localparam logic [7:0] L_COEF [16] = '{
    8'd1,   8'd148, 8'd32,  8'd133, 8'd16,  8'd194, 8'd192, 8'd1,
    8'd251, 8'd1,   8'd192, 8'd194, 8'd16,  8'd133, 8'd32,  8'd148
  };

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_XS    = 3'd1,
    ST_LIN   = 3'd2,
    ST_FINAL = 3'd3,
    ST_HOLD  = 3'd4
  } kuz_state_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ GF_POLY[7:0]) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

endpackage

// File: rtl/kuznechik_r_step.sv
// rtl/kuznechik_r_step.sv - one R step: GF(2^8) linear combination prepended, block shifted one byte down
module kuznechik_r_step
  import kuznechik_pkg::*;
(
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);

  logic [7:0] l_acc;

  always_comb begin
    l_acc = '0;
    for (int i = 0; i < 16; i++) begin
      l_acc = l_acc ^ gf_mul(data_i[8*i +: 8], L_COEF[i]);
    end
  end

  assign data_o = {l_acc, data_i[127:8]};

endmodule

// File: rtl/table_convertion.sv
// rtl/table_convertion.sv - Kuznyechik pi byte substitution (combinational lookup)
module table_convertion (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  localparam logic [7:0] PI [256] = '{
    8'd252, 8'd238, 8'd221, 8'd17,  8'd207, 8'd110, 8'd49,  8'd22,
    8'd251, 8'd196, 8'd250, 8'd218, 8'd35,  8'd197, 8'd4,   8'd77,
    8'd233, 8'd119, 8'd240, 8'd219, 8'd147, 8'd46,  8'd153, 8'd186,
    8'd23,  8'd54,  8'd241, 8'd187, 8'd20,  8'd205, 8'd95,  8'd193,
    8'd249, 8'd24,  8'd101, 8'd90,  8'd226, 8'd92,  8'd239, 8'd33,
    8'd129, 8'd28,  8'd60,  8'd66,  8'd139, 8'd1,   8'd142, 8'd79,
    8'd5,   8'd132, 8'd2,   8'd174, 8'd227, 8'd106, 8'd143, 8'd160,
    8'd6,   8'd11,  8'd237, 8'd152, 8'd127, 8'd212, 8'd211, 8'd31,
    8'd235, 8'd52,  8'd44,  8'd81,  8'd234, 8'd200, 8'd72,  8'd171,
    8'd242, 8'd42,  8'd104, 8'd162, 8'd253, 8'd58,  8'd206, 8'd204,
    8'd181, 8'd112, 8'd14,  8'd86,  8'd8,   8'd12,  8'd118, 8'd18,
    8'd191, 8'd114, 8'd19,  8'd71,  8'd156, 8'd183, 8'd93,  8'd135,
    8'd21,  8'd161, 8'd150, 8'd41,  8'd16,  8'd123, 8'd154, 8'd199,
    8'd243, 8'd145, 8'd120, 8'd111, 8'd157, 8'd158, 8'd178, 8'd177,
    8'd50,  8'd117, 8'd25,  8'd61,  8'd255, 8'd53,  8'd138, 8'd126,
    8'd109, 8'd84,  8'd198, 8'd128, 8'd195, 8'd189, 8'd13,  8'd87,
    8'd223, 8'd245, 8'd36,  8'd169, 8'd62,  8'd168, 8'd67,  8'd201,
    8'd215, 8'd121, 8'd214, 8'd246, 8'd124, 8'd34,  8'd185, 8'd3,
    8'd224, 8'd15,  8'd236, 8'd222, 8'd122, 8'd148, 8'd176, 8'd188,
    8'd220, 8'd232, 8'd40,  8'd80,  8'd78,  8'd51,  8'd10,  8'd74,
    8'd167, 8'd151, 8'd96,  8'd115, 8'd30,  8'd0,   8'd98,  8'd68,
    8'd26,  8'd184, 8'd56,  8'd130, 8'd100, 8'd159, 8'd38,  8'd65,
    8'd173, 8'd69,  8'd70,  8'd146, 8'd39,  8'd94,  8'd85,  8'd47,
    8'd140, 8'd163, 8'd165, 8'd125, 8'd105, 8'd213, 8'd149, 8'd59,
    8'd7,   8'd88,  8'd179, 8'd64,  8'd134, 8'd172, 8'd29,  8'd247,
    8'd48,  8'd55,  8'd107, 8'd228, 8'd136, 8'd217, 8'd231, 8'd137,
    8'd225, 8'd27,  8'd131, 8'd73,  8'd76,  8'd63,  8'd248, 8'd254,
    8'd141, 8'd83,  8'd170, 8'd144, 8'd202, 8'd216, 8'd133, 8'd97,
    8'd32,  8'd113, 8'd103, 8'd164, 8'd45,  8'd43,  8'd9,   8'd91,
    8'd203, 8'd155, 8'd37,  8'd208, 8'd190, 8'd229, 8'd108, 8'd82,
    8'd89,  8'd166, 8'd116, 8'd210, 8'd230, 8'd244, 8'd180, 8'd192,
    8'd209, 8'd102, 8'd175, 8'd194, 8'd57,  8'd75,  8'd99,  8'd182
  };

  assign data_o = PI[data_i];

endmodule

// File: rtl/kuznechik_encrypt.sv
// rtl/kuznechik_encrypt.sv - iterative Kuznyechik block encryption, one S cycle plus 16 R cycles per round
module kuznechik_encrypt
  import kuznechik_pkg::*;
#(
  parameter int unsigned ROUNDS = KUZ_ROUNDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         keys_valid,
  input  logic [127:0] data_in,
  input  logic [127:0] key_1,
  input  logic [127:0] key_2,
  input  logic [127:0] key_3,
  input  logic [127:0] key_4,
  input  logic [127:0] key_5,
  input  logic [127:0] key_6,
  input  logic [127:0] key_7,
  input  logic [127:0] key_8,
  input  logic [127:0] key_9,
  input  logic [127:0] key_10,
  output logic [127:0] data_out,
  output logic         busy,
  output logic         finish
);

  kuz_state_e   state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [3:0]   rc_q, rc_d;
  logic [127:0] dout_q, dout_d;
  logic         busy_q, busy_d;
  logic         finish_q, finish_d;

  logic [127:0] round_key;
  logic [127:0] xs_in;
  logic [127:0] s_out;
  logic [127:0] r_out;

  always_comb begin
    case (rnd_q)
      4'd0:    round_key = key_1;
      4'd1:    round_key = key_2;
      4'd2:    round_key = key_3;
      4'd3:    round_key = key_4;
      4'd4:    round_key = key_5;
      4'd5:    round_key = key_6;
      4'd6:    round_key = key_7;
      4'd7:    round_key = key_8;
      4'd8:    round_key = key_9;
      default: round_key = '0;
    endcase
  end

  assign xs_in = st_q ^ round_key;

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    table_convertion u_sbox (
      .data_i (xs_in[8*g +: 8]),
      .data_o (s_out[8*g +: 8])
    );
  end

  kuznechik_r_step u_r_step (
    .data_i (st_q),
    .data_o (r_out)
  );

  always_comb begin
    state_d  = state_q;
    st_d     = st_q;
    rnd_d    = rnd_q;
    rc_d     = rc_q;
    dout_d   = dout_q;
    busy_d   = busy_q;
    finish_d = finish_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && keys_valid) begin
          st_d    = data_in;
          rnd_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_XS;
        end
      end
      ST_XS: begin
        st_d    = s_out;
        rc_d    = '0;
        state_d = ST_LIN;
      end
      ST_LIN: begin
        st_d = r_out;
        rc_d = rc_q + 4'd1;
        if (rc_q == 4'(R_STEPS - 1)) begin
          if (rnd_q == 4'(ROUNDS - 1)) begin
            state_d = ST_FINAL;
          end else begin
            rnd_d   = rnd_q + 4'd1;
            state_d = ST_XS;
          end
        end
      end
      ST_FINAL: begin
        dout_d   = st_q ^ key_10;
        finish_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_HOLD;
      end
      ST_HOLD: begin
        // A new request needs enable to drop first, so a held level cannot re-trigger.
        if (!enable) begin
          finish_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      st_q     <= '0;
      rnd_q    <= '0;
      rc_q     <= '0;
      dout_q   <= '0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      st_q     <= st_d;
      rnd_q    <= rnd_d;
      rc_q     <= rc_d;
      dout_q   <= dout_d;
      busy_q   <= busy_d;
      finish_q <= finish_d;
    end
  end

  assign data_out = dout_q;
  assign busy     = busy_q;
  assign finish   = finish_q;

endmodule
